// File: rtl/amo_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : amo_rmw_ctrl (with helper amo_rmw_amoalu)
// Brief    : One-at-a-time AMO read-modify-write sequencer with embedded AMOALU
// Revision : 1.0 - initial release
// ============================================================================

module amo_rmw_amoalu (
    input  logic [3:0]  io_mask,
    input  logic [4:0]  io_cmd,
    input  logic [31:0] io_lhs,
    input  logic [31:0] io_rhs,
    output logic [31:0] io_out
);

    localparam logic [4:0] c_CMD_SWAP = 5'h04;
    localparam logic [4:0] c_CMD_ADD  = 5'h08;
    localparam logic [4:0] c_CMD_XOR  = 5'h09;
    localparam logic [4:0] c_CMD_OR   = 5'h0a;
    localparam logic [4:0] c_CMD_AND  = 5'h0b;
    localparam logic [4:0] c_CMD_MIN  = 5'h0c;
    localparam logic [4:0] c_CMD_MAX  = 5'h0d;
    localparam logic [4:0] c_CMD_MINU = 5'h0e;
    localparam logic [4:0] c_CMD_MAXU = 5'h0f;

    logic        w_slt;
    logic        w_ult;
    logic [31:0] w_result;
    logic [31:0] w_bytemask;

    assign w_slt = $signed(io_lhs) < $signed(io_rhs);
    assign w_ult = io_lhs < io_rhs;

    always_comb begin
        w_result = io_lhs;
        case (io_cmd)
            c_CMD_SWAP: w_result = io_rhs;
            c_CMD_ADD:  w_result = io_lhs + io_rhs;
            c_CMD_XOR:  w_result = io_lhs ^ io_rhs;
            c_CMD_OR:   w_result = io_lhs | io_rhs;
            c_CMD_AND:  w_result = io_lhs & io_rhs;
            c_CMD_MIN:  w_result = w_slt ? io_lhs : io_rhs;
            c_CMD_MAX:  w_result = w_slt ? io_rhs : io_lhs;
            c_CMD_MINU: w_result = w_ult ? io_lhs : io_rhs;
            c_CMD_MAXU: w_result = w_ult ? io_rhs : io_lhs;
            default:    w_result = io_lhs;
        endcase
    end

    // Unselected bytes keep the old memory contents.
    assign w_bytemask = {{8{io_mask[3]}}, {8{io_mask[2]}}, {8{io_mask[1]}}, {8{io_mask[0]}}};
    assign io_out     = (w_result & w_bytemask) | (io_lhs & ~w_bytemask);

endmodule

module amo_rmw_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_req_valid,
    output logic              io_req_ready,
    input  logic [4:0]        io_req_cmd,
    input  logic [ADDR_W-1:0] io_req_addr,
    input  logic [31:0]       io_req_data,
    input  logic [3:0]        io_req_mask,
    output logic              io_mem_req_valid,
    input  logic              io_mem_req_ready,
    output logic              io_mem_req_wen,
    output logic [ADDR_W-1:0] io_mem_req_addr,
    output logic [31:0]       io_mem_req_wdata,
    output logic [3:0]        io_mem_req_wmask,
    input  logic              io_mem_resp_valid,
    input  logic [31:0]       io_mem_resp_data,
    output logic              io_resp_valid,
    input  logic              io_resp_ready,
    output logic [31:0]       io_resp_data,
    output logic              io_resp_err,
    output logic              io_busy
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_RD_REQ  = 3'd1;
    localparam logic [2:0] c_RD_WAIT = 3'd2;
    localparam logic [2:0] c_EXEC    = 3'd3;
    localparam logic [2:0] c_WR_REQ  = 3'd4;
    localparam logic [2:0] c_RESP    = 3'd5;

    localparam logic [4:0] c_CMD_SWAP = 5'h04;
    localparam logic [7:0] c_TIMEOUT  = 8'(TIMEOUT);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [4:0]        r_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic [3:0]        r_mask;
    logic [31:0]       r_old;
    logic [31:0]       r_new;
    logic              r_err;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_inc;
    logic              w_cmd_legal;
    logic              w_req_ok;
    logic [31:0]       w_alu_out;

    // swap is 0x4; every arithmetic/logic op lives in 0x8..0xf.
    assign w_cmd_legal = (io_req_cmd == c_CMD_SWAP) || (io_req_cmd[4:3] == 2'b01);
    assign w_req_ok    = w_cmd_legal && (io_req_addr[1:0] == 2'b00);
    assign w_cnt_inc   = r_cnt + 8'd1;

    amo_rmw_amoalu u_amoalu (
        .io_mask (r_mask),
        .io_cmd  (r_cmd),
        .io_lhs  (r_old),
        .io_rhs  (r_data),
        .io_out  (w_alu_out)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (io_req_valid) begin
                    w_state_nxt = w_req_ok ? c_RD_REQ : c_RESP;
                end
            end
            c_RD_REQ: begin
                if (io_mem_req_ready) begin
                    w_state_nxt = c_RD_WAIT;
                end
            end
            c_RD_WAIT: begin
                // A response arriving on the final wait cycle beats the timeout.
                if (io_mem_resp_valid) begin
                    w_state_nxt = c_EXEC;
                end else if (w_cnt_inc == c_TIMEOUT) begin
                    w_state_nxt = c_RESP;
                end
            end
            c_EXEC: begin
                w_state_nxt = c_WR_REQ;
            end
            c_WR_REQ: begin
                if (io_mem_req_ready) begin
                    w_state_nxt = c_RESP;
                end
            end
            c_RESP: begin
                if (io_resp_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cmd  <= '0;
            r_addr <= '0;
            r_data <= '0;
            r_mask <= '0;
            r_old  <= '0;
            r_new  <= '0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (io_req_valid) begin
                        r_cmd  <= io_req_cmd;
                        r_addr <= io_req_addr;
                        r_data <= io_req_data;
                        r_mask <= io_req_mask;
                        r_old  <= '0;
                        r_new  <= '0;
                        r_err  <= ~w_req_ok;
                    end
                end
                c_RD_REQ: begin
                    if (io_mem_req_ready) begin
                        r_cnt <= '0;
                    end
                end
                c_RD_WAIT: begin
                    if (io_mem_resp_valid) begin
                        r_old <= io_mem_resp_data;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == c_TIMEOUT) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_EXEC: begin
                    r_new <= w_alu_out;
                end
                default: begin
                end
            endcase
        end
    end

    assign io_req_ready     = (r_state == c_IDLE);
    assign io_busy          = (r_state != c_IDLE);
    assign io_mem_req_valid = (r_state == c_RD_REQ) || (r_state == c_WR_REQ);
    assign io_mem_req_wen   = (r_state == c_WR_REQ);
    assign io_mem_req_addr  = r_addr;
    assign io_mem_req_wdata = r_new;
    assign io_mem_req_wmask = r_mask;
    assign io_resp_valid    = (r_state == c_RESP);
    assign io_resp_err      = (r_state == c_RESP) && r_err;
    assign io_resp_data     = r_err ? 32'h0 : r_old;

endmodule

`default_nettype wire

// File: tb/tb_amo_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_amo_rmw_ctrl
// Brief    : Directed self-checking bench for amo_rmw_ctrl with a memory model
// Revision : 1.0 - initial release
// ============================================================================

module tb_amo_rmw_ctrl;

    localparam int c_ADDR_W  = 32;
    localparam int c_TIMEOUT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_req_valid = 1'b0;
    logic        io_req_ready;
    logic [4:0]  io_req_cmd = '0;
    logic [31:0] io_req_addr = '0;
    logic [31:0] io_req_data = '0;
    logic [3:0]  io_req_mask = '0;
    logic        io_mem_req_valid;
    logic        io_mem_req_ready = 1'b0;
    logic        io_mem_req_wen;
    logic [31:0] io_mem_req_addr;
    logic [31:0] io_mem_req_wdata;
    logic [3:0]  io_mem_req_wmask;
    logic        io_mem_resp_valid = 1'b0;
    logic [31:0] io_mem_resp_data = '0;
    logic        io_resp_valid;
    logic        io_resp_ready = 1'b1;
    logic [31:0] io_resp_data;
    logic        io_resp_err;
    logic        io_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model controls (written by the test sequence only)
    logic [31:0] mem [0:255];
    int          rd_stall   = 0;
    int          wr_stall   = 0;
    int          resp_delay = 0;
    bit          resp_en    = 1'b1;
    int          inject_req = 0;
    logic [31:0] inject_data = '0;

    // Memory model observations (written by the driver only)
    int          cyc = 0;
    int          rd_count = 0;
    int          wr_count = 0;
    int          mem_valid_cycles = 0;
    int          resp_cycles = 0;
    int          resp_hs = 0;
    int          stall_viol = 0;
    int          rd_hs_cyc = 0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_wmask = '0;
    logic [31:0] last_waddr = '0;

    always #5 clock = ~clock;

    amo_rmw_ctrl #(
        .ADDR_W  (c_ADDR_W),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .io_req_valid      (io_req_valid),
        .io_req_ready      (io_req_ready),
        .io_req_cmd        (io_req_cmd),
        .io_req_addr       (io_req_addr),
        .io_req_data       (io_req_data),
        .io_req_mask       (io_req_mask),
        .io_mem_req_valid  (io_mem_req_valid),
        .io_mem_req_ready  (io_mem_req_ready),
        .io_mem_req_wen    (io_mem_req_wen),
        .io_mem_req_addr   (io_mem_req_addr),
        .io_mem_req_wdata  (io_mem_req_wdata),
        .io_mem_req_wmask  (io_mem_req_wmask),
        .io_mem_resp_valid (io_mem_resp_valid),
        .io_mem_resp_data  (io_mem_resp_data),
        .io_resp_valid     (io_resp_valid),
        .io_resp_ready     (io_resp_ready),
        .io_resp_data      (io_resp_data),
        .io_resp_err       (io_resp_err),
        .io_busy           (io_busy)
    );

    // Memory responder: drives inputs on the falling edge, samples mid-low-phase,
    // and attributes every observed handshake to the next rising edge.
    initial begin : g_mem_model
        int          stall_cnt;
        int          inject_done;
        int          pend_cnt;
        bit          pending;
        bit          hold_flag;
        logic [31:0] pend_data;
        logic [68:0] held;
        stall_cnt = 0; inject_done = 0; pend_cnt = 0; pending = 0; hold_flag = 0;
        pend_data = '0; held = '0;
        forever begin
            @(negedge clock);
            io_mem_resp_valid = 1'b0;
            if (inject_done != inject_req) begin
                inject_done       = inject_req;
                io_mem_resp_valid = 1'b1;
                io_mem_resp_data  = inject_data;
            end else if (pending) begin
                if (pend_cnt == 0) begin
                    io_mem_resp_valid = 1'b1;
                    io_mem_resp_data  = pend_data;
                    pending           = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (io_mem_req_valid === 1'b1) begin
                if (stall_cnt < (io_mem_req_wen ? wr_stall : rd_stall)) begin
                    io_mem_req_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    io_mem_req_ready = 1'b1;
                end
            end else begin
                io_mem_req_ready = 1'b0;
                stall_cnt        = 0;
            end
            #2;
            if (!reset) begin
                pending   = 1'b0;
                hold_flag = 1'b0;
            end
            if (io_mem_req_valid === 1'b1) begin
                mem_valid_cycles++;
                if (hold_flag && ({io_mem_req_wen, io_mem_req_addr, io_mem_req_wdata, io_mem_req_wmask} !== held))
                    stall_viol++;
                if (io_mem_req_ready) begin
                    hold_flag = 1'b0;
                    if (io_mem_req_wen) begin
                        wr_count++;
                        last_wdata = io_mem_req_wdata;
                        last_wmask = io_mem_req_wmask;
                        last_waddr = io_mem_req_addr;
                    end else begin
                        rd_count++;
                        rd_hs_cyc = cyc + 1;
                        pending   = resp_en;
                        pend_cnt  = resp_delay;
                        pend_data = mem[io_mem_req_addr[9:2]];
                    end
                end else begin
                    hold_flag = 1'b1;
                    held      = {io_mem_req_wen, io_mem_req_addr, io_mem_req_wdata, io_mem_req_wmask};
                end
            end else begin
                hold_flag = 1'b0;
            end
            if (io_resp_valid === 1'b1) begin
                resp_cycles++;
                if (io_resp_ready) resp_hs++;
            end
            @(posedge clock);
            cyc++;
        end
    end

    initial begin : g_watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Presents a request at a falling edge and returns at the falling edge
    // after the accepting rising edge; t_acc is the accepting edge number.
    task automatic send_req(input logic [4:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] mask,
                            output int t_acc);
        @(negedge clock);
        io_req_valid = 1'b1;
        io_req_cmd   = cmd;
        io_req_addr  = addr;
        io_req_data  = data;
        io_req_mask  = mask;
        t_acc        = -1;
        for (int i = 0; i < 50 && t_acc < 0; i++) begin
            if (io_req_ready === 1'b1) t_acc = cyc + 1;
            @(negedge clock);
        end
        io_req_valid = 1'b0;
        n_checks++;
        if (t_acc < 0) begin
            n_errors++;
            $display("FAIL req_accept: io_req_ready never 1 within 50 cycles (required 1)");
        end
    endtask

    // Waits (at falling edges) for io_resp_valid; t_resp is the edge count it was seen after.
    task automatic wait_resp(output int t_resp);
        t_resp = -1;
        for (int i = 0; i < 200 && t_resp < 0; i++) begin
            if (io_resp_valid === 1'b1) t_resp = cyc;
            else @(negedge clock);
        end
        n_checks++;
        if (t_resp < 0) begin
            n_errors++;
            $display("FAIL resp_wait: io_resp_valid never 1 within 200 cycles (required 1)");
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_checks += 5;
        if (io_req_ready !== 1'b1)     begin n_errors++; $display("FAIL rst_req_ready: got %b required 1", io_req_ready); end
        if (io_mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mem_valid: got %b required 0", io_mem_req_valid); end
        if (io_resp_valid !== 1'b0)    begin n_errors++; $display("FAIL rst_resp_valid: got %b required 0", io_resp_valid); end
        if (io_resp_err !== 1'b0)      begin n_errors++; $display("FAIL rst_resp_err: got %b required 0", io_resp_err); end
        if (io_busy !== 1'b0)          begin n_errors++; $display("FAIL rst_busy: got %b required 0", io_busy); end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if (io_busy !== 1'b0 || io_req_ready !== 1'b1) begin
            n_errors++; $display("FAIL rst_release_idle: busy=%b ready=%b required busy=0 ready=1", io_busy, io_req_ready);
        end
    endtask

    task automatic test_add;
        int t, tr, rd0, wr0;
        mem[8'h40] = 32'h7fffffff;
        rd0 = rd_count; wr0 = wr_count;
        send_req(5'h08, 32'h100, 32'h1, 4'hf, t);
        wait_resp(tr);
        n_checks += 6;
        if (tr + 1 != t + 5)              begin n_errors++; $display("FAIL add_latency: resp edge t+%0d required t+5", tr + 1 - t); end
        if (io_resp_data !== 32'h7fffffff) begin n_errors++; $display("FAIL add_resp_data: got %h required 7fffffff", io_resp_data); end
        if (io_resp_err !== 1'b0)         begin n_errors++; $display("FAIL add_resp_err: got %b required 0", io_resp_err); end
        if (last_wdata !== 32'h80000000)  begin n_errors++; $display("FAIL add_wdata: got %h required 80000000", last_wdata); end
        if (last_wmask !== 4'hf)          begin n_errors++; $display("FAIL add_wmask: got %h required f", last_wmask); end
        if (last_waddr !== 32'h100)       begin n_errors++; $display("FAIL add_waddr: got %h required 00000100", last_waddr); end
        @(negedge clock);
        n_checks++;
        if (rd_count - rd0 != 1 || wr_count - wr0 != 1) begin
            n_errors++; $display("FAIL add_access_count: reads=%0d writes=%0d required 1 and 1", rd_count - rd0, wr_count - wr0);
        end
    endtask

    task automatic test_signed;
        logic [4:0]  cmds  [2] = '{5'h0c, 5'h0e};
        logic [31:0] wexp  [2] = '{32'hfffffffe, 32'h00000005};
        int t, tr;
        for (int i = 0; i < 2; i++) begin
            mem[8'h41] = 32'hfffffffe;
            send_req(cmds[i], 32'h104, 32'h5, 4'hf, t);
            wait_resp(tr);
            n_checks += 2;
            if (io_resp_data !== 32'hfffffffe) begin
                n_errors++; $display("FAIL minmax_resp cmd=%h: got %h required fffffffe", cmds[i], io_resp_data);
            end
            if (last_wdata !== wexp[i]) begin
                n_errors++; $display("FAIL minmax_wdata cmd=%h: got %h required %h", cmds[i], last_wdata, wexp[i]);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_mask_swap;
        int t, tr;
        mem[8'h80] = 32'h11223344;
        send_req(5'h04, 32'h200, 32'haabbccdd, 4'h3, t);
        wait_resp(tr);
        n_checks += 3;
        if (last_wdata !== 32'h1122ccdd)   begin n_errors++; $display("FAIL swap_wdata: got %h required 1122ccdd", last_wdata); end
        if (last_wmask !== 4'h3)           begin n_errors++; $display("FAIL swap_wmask: got %h required 3", last_wmask); end
        if (io_resp_data !== 32'h11223344) begin n_errors++; $display("FAIL swap_resp: got %h required 11223344", io_resp_data); end
        @(negedge clock);
    endtask

    task automatic test_backpressure;
        int t, tr, rd0, wr0, hs0, mv0, sv0, rdy_viol, hold_bad;
        logic [31:0] d0;
        mem[8'h42] = 32'h0f0f0f0f;
        rd_stall = 3; wr_stall = 3;
        io_resp_ready = 1'b0;
        rd0 = rd_count; wr0 = wr_count; hs0 = resp_hs; mv0 = mem_valid_cycles; sv0 = stall_viol;
        send_req(5'h09, 32'h108, 32'hff00ff00, 4'hf, t);
        rdy_viol = 0;
        tr = -1;
        for (int i = 0; i < 100 && tr < 0; i++) begin
            if (io_req_ready !== 1'b0) rdy_viol++;
            if (io_resp_valid === 1'b1) tr = cyc;
            else @(negedge clock);
        end
        d0 = io_resp_data;
        n_checks += 3;
        if (tr + 1 != t + 11)        begin n_errors++; $display("FAIL bp_latency: resp edge t+%0d required t+11", tr + 1 - t); end
        if (d0 !== 32'h0f0f0f0f)     begin n_errors++; $display("FAIL bp_resp_data: got %h required 0f0f0f0f", d0); end
        if (last_wdata !== 32'hf00ff00f) begin n_errors++; $display("FAIL bp_wdata: got %h required f00ff00f", last_wdata); end
        hold_bad = 0;
        repeat (2) begin
            @(negedge clock);
            if (io_resp_valid !== 1'b1 || io_resp_data !== d0 || io_req_ready !== 1'b0) hold_bad++;
        end
        io_resp_ready = 1'b1;
        @(negedge clock);
        n_checks += 6;
        if (hold_bad != 0)  begin n_errors++; $display("FAIL bp_resp_hold: %0d unstable cycles required 0", hold_bad); end
        if (rdy_viol != 0)  begin n_errors++; $display("FAIL bp_req_ready: high %0d cycles while busy required 0", rdy_viol); end
        if (stall_viol - sv0 != 0) begin n_errors++; $display("FAIL bp_mem_hold: %0d field changes required 0", stall_viol - sv0); end
        if (mem_valid_cycles - mv0 != 8) begin n_errors++; $display("FAIL bp_mem_valid_cycles: got %0d required 8", mem_valid_cycles - mv0); end
        if (rd_count - rd0 != 1 || wr_count - wr0 != 1 || resp_hs - hs0 != 1) begin
            n_errors++; $display("FAIL bp_counts: reads=%0d writes=%0d resps=%0d required 1 1 1", rd_count - rd0, wr_count - wr0, resp_hs - hs0);
        end
        if (io_resp_valid !== 1'b0 || io_req_ready !== 1'b1) begin
            n_errors++; $display("FAIL bp_after_hs: resp_valid=%b req_ready=%b required 0 and 1", io_resp_valid, io_req_ready);
        end
        rd_stall = 0; wr_stall = 0;
    endtask

    task automatic test_errors;
        logic [4:0]  ecmd  [2] = '{5'h00, 5'h08};
        logic [31:0] eaddr [2] = '{32'h100, 32'h102};
        int t, tr, mv0, rd0, wr0;
        for (int i = 0; i < 2; i++) begin
            mv0 = mem_valid_cycles;
            send_req(ecmd[i], eaddr[i], 32'h1, 4'hf, t);
            wait_resp(tr);
            n_checks += 3;
            if (tr + 1 != t + 1)     begin n_errors++; $display("FAIL err%0d_latency: resp edge t+%0d required t+1", i, tr + 1 - t); end
            if (io_resp_err !== 1'b1) begin n_errors++; $display("FAIL err%0d_flag: got %b required 1", i, io_resp_err); end
            if (io_resp_data !== 32'h0) begin n_errors++; $display("FAIL err%0d_data: got %h required 0", i, io_resp_data); end
            @(negedge clock);
            n_checks++;
            if (mem_valid_cycles - mv0 != 0) begin n_errors++; $display("FAIL err%0d_no_mem: %0d mem cycles required 0", i, mem_valid_cycles - mv0); end
        end

        // Read never answered: abort after TIMEOUT wait cycles, no write
        resp_en = 1'b0;
        mem[8'h40] = 32'h12345678;
        rd0 = rd_count; wr0 = wr_count;
        send_req(5'h08, 32'h100, 32'h1, 4'hf, t);
        wait_resp(tr);
        n_checks += 3;
        if (tr - rd_hs_cyc != 4)  begin n_errors++; $display("FAIL tmo_latency: resp %0d cycles after read required 4", tr - rd_hs_cyc); end
        if (io_resp_err !== 1'b1) begin n_errors++; $display("FAIL tmo_flag: got %b required 1", io_resp_err); end
        if (io_resp_data !== 32'h0) begin n_errors++; $display("FAIL tmo_data: got %h required 0", io_resp_data); end
        @(negedge clock);
        n_checks++;
        if (rd_count - rd0 != 1 || wr_count - wr0 != 0) begin
            n_errors++; $display("FAIL tmo_counts: reads=%0d writes=%0d required 1 and 0", rd_count - rd0, wr_count - wr0);
        end
        resp_en = 1'b1;

        // Response on the last wait cycle wins over the timeout
        resp_delay = 3;
        mem[8'h40] = 32'h00000010;
        send_req(5'h0a, 32'h100, 32'h1, 4'hf, t);
        wait_resp(tr);
        n_checks += 3;
        if (io_resp_err !== 1'b0)        begin n_errors++; $display("FAIL late_resp_err: got %b required 0", io_resp_err); end
        if (io_resp_data !== 32'h10)     begin n_errors++; $display("FAIL late_resp_data: got %h required 00000010", io_resp_data); end
        if (last_wdata !== 32'h11)       begin n_errors++; $display("FAIL late_resp_wdata: got %h required 00000011", last_wdata); end
        @(negedge clock);
        resp_delay = 0;
    endtask

    task automatic test_reset_midop;
        int t, tr, rd0, wr0, rc0, mv0;
        bit in_wait;
        resp_en = 1'b0;
        mem[8'h40] = 32'h5;
        rd0 = rd_count; wr0 = wr_count; rc0 = resp_cycles;
        send_req(5'h08, 32'h100, 32'h3, 4'hf, t);
        in_wait = 1'b0;
        for (int i = 0; i < 50 && !in_wait; i++) begin
            if (rd_count - rd0 >= 1) in_wait = 1'b1;
            else @(negedge clock);
        end
        n_checks++;
        if (!in_wait || io_busy !== 1'b1) begin
            n_errors++; $display("FAIL midop_reach_wait: read_seen=%b busy=%b required 1 1", in_wait, io_busy);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (io_busy !== 1'b0 || io_req_ready !== 1'b1 || io_mem_req_valid !== 1'b0 || io_resp_valid !== 1'b0) begin
            n_errors++; $display("FAIL midop_async_reset: busy=%b ready=%b memv=%b respv=%b required 0 1 0 0",
                                 io_busy, io_req_ready, io_mem_req_valid, io_resp_valid);
        end
        @(negedge clock);
        reset = 1'b1;
        mv0 = mem_valid_cycles;
        @(negedge clock);
        inject_data = 32'hdeadbeef;
        inject_req++;
        repeat (6) @(negedge clock);
        n_checks += 3;
        if (wr_count - wr0 != 0 || mem_valid_cycles - mv0 != 0) begin
            n_errors++; $display("FAIL midop_no_mem: writes=%0d mem cycles=%0d required 0 0", wr_count - wr0, mem_valid_cycles - mv0);
        end
        if (resp_cycles - rc0 != 0) begin n_errors++; $display("FAIL midop_no_resp: got %0d resp cycles required 0", resp_cycles - rc0); end
        if (io_busy !== 1'b0 || io_req_ready !== 1'b1) begin
            n_errors++; $display("FAIL midop_idle: busy=%b ready=%b required 0 1", io_busy, io_req_ready);
        end
        resp_en = 1'b1;
        send_req(5'h08, 32'h100, 32'h3, 4'hf, t);
        wait_resp(tr);
        n_checks += 3;
        if (io_resp_data !== 32'h5) begin n_errors++; $display("FAIL midop_next_resp: got %h required 00000005", io_resp_data); end
        if (io_resp_err !== 1'b0)   begin n_errors++; $display("FAIL midop_next_err: got %b required 0", io_resp_err); end
        if (last_wdata !== 32'h8)   begin n_errors++; $display("FAIL midop_next_wdata: got %h required 00000008", last_wdata); end
        @(negedge clock);
    endtask

    initial begin : g_main
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset;
        test_add;
        test_signed;
        test_mask_swap;
        test_backpressure;
        test_errors;
        test_reset_midop;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
